// File: rtl/y86_pkg.sv
// Shared Y86 pipeline definitions: status codes, register/icode constants and
// the control-field bundle carried between pipeline stages.
package y86_pkg;

    localparam logic [2:0] STAT_AOK = 3'd1;
    localparam logic [2:0] STAT_HLT = 3'd2;
    localparam logic [2:0] STAT_ADR = 3'd3;
    localparam logic [2:0] STAT_INS = 3'd4;

    localparam logic [3:0] ICODE_NOP = 4'h1;
    localparam logic [3:0] REG_NONE  = 4'hF;

    typedef struct packed {
        logic [2:0] status;
        logic [3:0] icode;
        logic [3:0] rA;
        logic [3:0] rB;
        logic       cnd;
    } pipe_ctrl_t;

    localparam pipe_ctrl_t PIPE_CTRL_BUBBLE = '{
        status: STAT_AOK,
        icode:  ICODE_NOP,
        rA:     REG_NONE,
        rB:     REG_NONE,
        cnd:    1'b0
    };

    typedef enum logic [1:0] {
        ACT_HOLD,
        ACT_BUBBLE,
        ACT_LOAD
    } pipe_act_t;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous active-low clear; sticks at all-ones.
module sat_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         inc,
    output logic [W-1:0] count
);

    logic [W-1:0] count_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            count_q <= '0;
        end else if (inc && (count_q != {W{1'b1}})) begin
            count_q <= count_q + {{(W-1){1'b0}}, 1'b1};
        end
    end

    assign count = count_q;

endmodule

// File: rtl/y86_pipe_reg.sv
// Generic Y86 stage boundary register with stall, bubble injection, optional
// sticky freeze on exceptional status, and saturating stall/bubble counters.
module y86_pipe_reg
    import y86_pkg::*;
#(
    parameter int NVAL          = 6,
    parameter int WORD_W        = 64,
    parameter int CNT_W         = 16,
    parameter bit FREEZE_ON_EXC = 1'b0
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   stall,
    input  logic                   bubble,
    input  logic [2:0]             in_status,
    input  logic [3:0]             in_icode,
    input  logic [3:0]             in_rA,
    input  logic [3:0]             in_rB,
    input  logic                   in_cnd,
    input  logic [NVAL*WORD_W-1:0] in_vals,
    output logic [2:0]             out_status,
    output logic [3:0]             out_icode,
    output logic [3:0]             out_rA,
    output logic [3:0]             out_rB,
    output logic                   out_cnd,
    output logic [NVAL*WORD_W-1:0] out_vals,
    output logic                   out_valid,
    output logic                   frozen,
    output logic                   conflict,
    output logic [CNT_W-1:0]       stall_cnt,
    output logic [CNT_W-1:0]       bubble_cnt
);

    pipe_ctrl_t             ctrl_q, ctrl_d;
    logic [NVAL*WORD_W-1:0] vals_q, vals_d;
    logic                   valid_q, valid_d;
    logic                   frozen_q, frozen_d;
    logic                   conflict_q, conflict_d;
    pipe_act_t              act;

    // Priority: freeze hold, then bubble, then stall hold, else load.
    always_comb begin
        act        = ACT_LOAD;
        ctrl_d     = ctrl_q;
        vals_d     = vals_q;
        valid_d    = valid_q;
        frozen_d   = frozen_q;
        conflict_d = conflict_q | (stall & bubble);

        if (frozen_q) begin
            act = ACT_HOLD;
        end else if (bubble) begin
            act = ACT_BUBBLE;
        end else if (stall) begin
            act = ACT_HOLD;
        end

        case (act)
            ACT_BUBBLE: begin
                ctrl_d  = PIPE_CTRL_BUBBLE;
                vals_d  = '0;
                valid_d = 1'b0;
            end
            ACT_LOAD: begin
                ctrl_d.status = in_status;
                ctrl_d.icode  = in_icode;
                ctrl_d.rA     = in_rA;
                ctrl_d.rB     = in_rB;
                ctrl_d.cnd    = in_cnd;
                vals_d        = in_vals;
                valid_d       = 1'b1;
                if (FREEZE_ON_EXC && (in_status != STAT_AOK)) begin
                    frozen_d = 1'b1;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ctrl_q     <= PIPE_CTRL_BUBBLE;
            vals_q     <= '0;
            valid_q    <= 1'b0;
            frozen_q   <= 1'b0;
            conflict_q <= 1'b0;
        end else begin
            ctrl_q     <= ctrl_d;
            vals_q     <= vals_d;
            valid_q    <= valid_d;
            frozen_q   <= frozen_d;
            conflict_q <= conflict_d;
        end
    end

    // Counters see only the out-of-reset actions; freeze masks both.
    sat_counter #(.W(CNT_W)) u_stall_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (!frozen_q && !bubble && stall),
        .count (stall_cnt)
    );

    sat_counter #(.W(CNT_W)) u_bubble_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (!frozen_q && bubble),
        .count (bubble_cnt)
    );

    assign out_status = ctrl_q.status;
    assign out_icode  = ctrl_q.icode;
    assign out_rA     = ctrl_q.rA;
    assign out_rB     = ctrl_q.rB;
    assign out_cnd    = ctrl_q.cnd;
    assign out_vals   = vals_q;
    assign out_valid  = valid_q;
    assign frozen     = frozen_q;
    assign conflict   = conflict_q;

endmodule

// File: tb/tb_y86_pipe_reg.sv
// Scoreboard bench: two instances (default build, and a freezing 3-bit-counter
// build) share stimulus; a spec-level model predicts each edge's outputs.
module tb_y86_pipe_reg;

    localparam int VB = 384;

    logic          clk = 1'b0;
    logic          rst_n, stall, bubble, in_cnd;
    logic [2:0]    in_status;
    logic [3:0]    in_icode, in_rA, in_rB;
    logic [VB-1:0] in_vals;

    logic [2:0]    aStatus, bStatus;
    logic [3:0]    aIcode, aRA, aRB, bIcode, bRA, bRB;
    logic          aCnd, aValid, aFrozen, aConflict;
    logic          bCnd, bValid, bFrozen, bConflict;
    logic [VB-1:0] aVals;
    logic [127:0]  bVals;
    logic [15:0]   aStallCnt, aBubbleCnt;
    logic [2:0]    bStallCnt, bBubbleCnt;

    typedef struct {
        logic [2:0]    status;
        logic [3:0]    icode;
        logic [3:0]    rA;
        logic [3:0]    rB;
        logic          cnd;
        logic [VB-1:0] vals;
        logic          valid;
        logic          frozen;
        logic          conflict;
        int            scnt;
        int            bcnt;
    } exp_t;

    exp_t modelA, modelB, eA, eB;
    exp_t qA[$];
    exp_t qB[$];
    int   testsRun = 0;
    int   testsFailed = 0;

    always #5 clk = ~clk;

    y86_pipe_reg dutA (
        .clk(clk), .rst_n(rst_n), .stall(stall), .bubble(bubble),
        .in_status(in_status), .in_icode(in_icode), .in_rA(in_rA), .in_rB(in_rB),
        .in_cnd(in_cnd), .in_vals(in_vals),
        .out_status(aStatus), .out_icode(aIcode), .out_rA(aRA), .out_rB(aRB),
        .out_cnd(aCnd), .out_vals(aVals), .out_valid(aValid), .frozen(aFrozen),
        .conflict(aConflict), .stall_cnt(aStallCnt), .bubble_cnt(aBubbleCnt)
    );

    y86_pipe_reg #(.NVAL(2), .WORD_W(64), .CNT_W(3), .FREEZE_ON_EXC(1'b1)) dutB (
        .clk(clk), .rst_n(rst_n), .stall(stall), .bubble(bubble),
        .in_status(in_status), .in_icode(in_icode), .in_rA(in_rA), .in_rB(in_rB),
        .in_cnd(in_cnd), .in_vals(in_vals[127:0]),
        .out_status(bStatus), .out_icode(bIcode), .out_rA(bRA), .out_rB(bRB),
        .out_cnd(bCnd), .out_vals(bVals), .out_valid(bValid), .frozen(bFrozen),
        .conflict(bConflict), .stall_cnt(bStallCnt), .bubble_cnt(bBubbleCnt)
    );

    function automatic exp_t bubbleState(exp_t s);
        exp_t n = s;
        n.status = 3'd1;
        n.icode  = 4'h1;
        n.rA     = 4'hF;
        n.rB     = 4'hF;
        n.cnd    = 1'b0;
        n.vals   = '0;
        n.valid  = 1'b0;
        return n;
    endfunction

    // One clock edge of the block, straight from the action priority list.
    function automatic exp_t stepModel(exp_t s, bit freezeEn, int cntMax);
        exp_t n = s;
        if (!rst_n) begin
            n = bubbleState(s);
            n.frozen   = 1'b0;
            n.conflict = 1'b0;
            n.scnt     = 0;
            n.bcnt     = 0;
            return n;
        end
        if (stall && bubble) n.conflict = 1'b1;
        if (s.frozen) return n;
        if (bubble) begin
            n = bubbleState(n);
            n.bcnt = (s.bcnt < cntMax) ? s.bcnt + 1 : cntMax;
        end else if (stall) begin
            n.scnt = (s.scnt < cntMax) ? s.scnt + 1 : cntMax;
        end else begin
            n.status = in_status;
            n.icode  = in_icode;
            n.rA     = in_rA;
            n.rB     = in_rB;
            n.cnd    = in_cnd;
            n.vals   = in_vals;
            n.valid  = 1'b1;
            if (freezeEn && in_status != 3'd1) n.frozen = 1'b1;
        end
        return n;
    endfunction

    function automatic logic [VB-1:0] randVals();
        logic [VB-1:0] v;
        for (int i = 0; i < VB / 32; i++) v[i*32 +: 32] = $urandom;
        return v;
    endfunction

    task automatic applyStimulus(input logic r, input logic st, input logic bb,
                                 input logic [2:0] status, input logic [3:0] icode,
                                 input logic [3:0] ra, input logic [3:0] rb,
                                 input logic cnd, input logic [VB-1:0] vals);
        @(negedge clk);
        rst_n = r; stall = st; bubble = bb;
        in_status = status; in_icode = icode; in_rA = ra; in_rB = rb;
        in_cnd = cnd; in_vals = vals;
        modelA = stepModel(modelA, 1'b0, 65535);
        modelB = stepModel(modelB, 1'b1, 7);
        qA.push_back(modelA);
        qB.push_back(modelB);
    endtask

    task automatic applyRandom(input logic r, input logic st, input logic bb, input logic [2:0] status);
        applyStimulus(r, st, bb, status, 4'($urandom), 4'($urandom), 4'($urandom),
                      1'($urandom), randVals());
    endtask

    task automatic checkField(input string name, input logic [VB-1:0] act, input logic [VB-1:0] req);
        testsRun++;
        if (act !== req) begin
            testsFailed++;
            $display("[TB] FAIL %s at %0t: got %0h expected %0h", name, $time, act, req);
        end
    endtask

    task automatic checkOutput(input exp_t a, input exp_t b);
        checkField("A.status", VB'(aStatus), VB'(a.status));
        checkField("A.icode", VB'(aIcode), VB'(a.icode));
        checkField("A.rA", VB'(aRA), VB'(a.rA));
        checkField("A.rB", VB'(aRB), VB'(a.rB));
        checkField("A.cnd", VB'(aCnd), VB'(a.cnd));
        checkField("A.vals", aVals, a.vals);
        checkField("A.valid", VB'(aValid), VB'(a.valid));
        checkField("A.frozen", VB'(aFrozen), VB'(a.frozen));
        checkField("A.conflict", VB'(aConflict), VB'(a.conflict));
        checkField("A.stall_cnt", VB'(aStallCnt), VB'(a.scnt));
        checkField("A.bubble_cnt", VB'(aBubbleCnt), VB'(a.bcnt));
        checkField("B.status", VB'(bStatus), VB'(b.status));
        checkField("B.icode", VB'(bIcode), VB'(b.icode));
        checkField("B.rA", VB'(bRA), VB'(b.rA));
        checkField("B.rB", VB'(bRB), VB'(b.rB));
        checkField("B.cnd", VB'(bCnd), VB'(b.cnd));
        checkField("B.vals", VB'(bVals), VB'(b.vals[127:0]));
        checkField("B.valid", VB'(bValid), VB'(b.valid));
        checkField("B.frozen", VB'(bFrozen), VB'(b.frozen));
        checkField("B.conflict", VB'(bConflict), VB'(b.conflict));
        checkField("B.stall_cnt", VB'(bStallCnt), VB'(b.scnt));
        checkField("B.bubble_cnt", VB'(bBubbleCnt), VB'(b.bcnt));
    endtask

    // Monitor: every edge that had stimulus issued gets its prediction checked.
    always @(posedge clk) begin
        #1;
        if (qA.size() > 0 && qB.size() > 0) begin
            eA = qA.pop_front();
            eB = qB.pop_front();
            checkOutput(eA, eB);
        end
    end

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [VB-1:0] v;
        logic          st, bb;
        rst_n = 1'b0; stall = 1'b0; bubble = 1'b0; in_status = 3'd1;
        in_icode = '0; in_rA = '0; in_rB = '0; in_cnd = 1'b0; in_vals = '0;
        modelA = bubbleState(modelA);
        modelA.frozen = 1'b0; modelA.conflict = 1'b0; modelA.scnt = 0; modelA.bcnt = 0;
        modelB = modelA;

        // Reset with random inputs, including stall/bubble noise.
        for (int i = 0; i < 2; i++) applyRandom(1'b0, 1'($urandom), 1'($urandom), 3'($urandom));

        // Pass-through of three consecutive loads.
        for (int i = 0; i < 3; i++) begin
            v = randVals();
            v[4*64 +: 64] = 64'h1234 + 64'(i);
            applyStimulus(1'b1, 1'b0, 1'b0, 3'd1, 4'h6, 4'h2, 4'h3, 1'b1, v);
        end

        // Load then hold through four stalled edges.
        applyStimulus(1'b1, 1'b0, 1'b0, 3'd1, 4'h3, 4'h5, 4'h7, 1'b0, randVals());
        for (int i = 0; i < 4; i++) applyRandom(1'b1, 1'b1, 1'b0, 3'd1);

        // Simultaneous stall and bubble.
        applyRandom(1'b1, 1'b1, 1'b1, 3'd1);

        // Random traffic with AOK status so the freezing instance stays live.
        for (int i = 0; i < 200; i++) begin
            st = ($urandom_range(0, 3) == 0);
            bb = ($urandom_range(0, 6) == 0);
            applyRandom(1'b1, st, bb, 3'd1);
        end

        // Exceptional load freezes instance B; then new inputs and bubbles.
        applyStimulus(1'b1, 1'b0, 1'b0, 3'd3, 4'h5, 4'h1, 4'h2, 1'b1, randVals());
        for (int i = 0; i < 10; i++) begin
            bb = 1'($urandom);
            applyRandom(1'b1, 1'b0, bb, 3'($urandom_range(1, 4)));
        end
        applyRandom(1'b0, 1'b1, 1'b0, 3'd4);
        applyRandom(1'b1, 1'b0, 1'b0, 3'd1);

        // Reset mid-stall, then saturate the stall counter.
        applyRandom(1'b1, 1'b1, 1'b0, 3'd1);
        applyRandom(1'b0, 1'b1, 1'b0, 3'd1);
        applyRandom(1'b1, 1'b0, 1'b0, 3'd1);
        for (int i = 0; i < 10; i++) applyRandom(1'b1, 1'b1, 1'b0, 3'd1);
        for (int i = 0; i < 10; i++) applyRandom(1'b1, 1'b0, 1'b1, 3'd1);

        @(posedge clk);
        #3;
        testsRun++;
        if (qA.size() != 0 || qB.size() != 0) begin
            testsFailed++;
            $display("[TB] FAIL scoreboard drain: got %0d pending expected 0", qA.size() + qB.size());
        end
        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule

// File: doc/y86_pipe_reg.md
# y86_pipe_reg

Parametrised Y86 pipeline stage register, the generic successor to the fixed memory-to-writeback register. It latches stage control fields (status, icode, rA, rB, Cnd) plus `NVAL` 64-bit value words, and adds synchronous reset, stall (hold), bubble (NOP injection), an optional sticky freeze on exceptional status, and saturating stall/bubble counters. It is instantiated once per stage boundary (F/D, D/E, E/M, M/W), with each instance choosing its own `NVAL` and `FREEZE_ON_EXC`.

## Interface
- `NVAL`, 6: number of 64-bit value words carried (valC, valP, valA, valB, valE, valM order for the M/W instance).
- `WORD_W`, 64: width of each value word.
- `CNT_W`, 16: width of each performance counter.
- `FREEZE_ON_EXC`, 0: when 1, the first registered non-AOK status blocks all further loads until reset.

Ports:
- `clk`  in  1  rising-edge clock.
- `rst_n`  in  1  synchronous, active-low reset.
- `stall`  in  1  hold the current contents.
- `bubble`  in  1  load a NOP bubble.
- `in_status`  in  3  Y86 status (AOK=1, HLT=2, ADR=3, INS=4).
- `in_icode`, `in_rA`, `in_rB`  in  4 each  instruction fields.
- `in_cnd`  in  1  condition flag.
- `in_vals`  in  NVAL*WORD_W  packed value words; word 0 occupies the LSBs.
- `out_status`, `out_icode`, `out_rA`, `out_rB`, `out_cnd`, `out_vals`  out  same widths as the inputs  registered fields.
- `out_valid`  out  1  1 = real instruction, 0 = bubble/reset contents.
- `frozen`  out  1  sticky exception freeze is active.
- `conflict`  out  1  sticky: `stall` and `bubble` were asserted in the same cycle.
- `stall_cnt`, `bubble_cnt`  out  CNT_W each  saturating event counts.

## Operation
- The bubble value is: status=1 (AOK), icode=4'h1 (NOP), rA=rB=4'hF (RNONE), cnd=0, vals=0, valid=0.
- Reset (`rst_n`=0 at a clock edge) loads the bubble value, and clears `frozen`, `conflict` and both counters. Reset overrides every other input.
- Action priority when out of reset, first match wins:
  1. `frozen`=1: hold.
  2. `bubble`=1: load the bubble value.
  3. `stall`=1: hold.
  4. Otherwise: load the inputs, with `out_valid`=1.
- A hold retains every output field, including `out_valid`.
- When `stall` and `bubble` are both asserted, the bubble wins and `conflict` is set. `conflict` stays set until reset.
- `frozen` is set on the edge that loads (action 4) a value with `in_status`≠AOK, provided `FREEZE_ON_EXC`=1. The exceptional instruction itself is registered on that edge and is held afterwards. With `FREEZE_ON_EXC`=0, `frozen` is constantly 0.
- `stall_cnt` increments by 1 on each edge where action 3 is taken.
- `bubble_cnt` increments by 1 on each edge where action 2 is taken.
- Both counters saturate at 2^CNT_W−1 and never wrap.
- Counters do not increment while frozen or in reset.

## Timing
- Latency is 1 cycle: inputs sampled at edge N appear on the outputs after edge N.
- All outputs are registered. There are no combinational paths from input to output.
- `stall`/`bubble` take effect on the same edge at which they are sampled.
- Deasserting `rst_n` takes effect at the next edge. The first load can happen on the first edge with `rst_n`=1.
- Reset asserted while frozen or mid-stall returns the block to the bubble state in one edge.

## Structure
- Shared package `y86_pkg` holds:
  - status codes `STAT_AOK/HLT/ADR/INS`,
  - `ICODE_NOP`, `REG_NONE`,
  - a `pipe_ctrl_t` struct {status, icode, rA, rB, cnd} with its bubble constant.
- Sub-module `sat_counter` (parameter `W`; ports `clk`, `rst_n`, `inc`, `count`) is instantiated twice, once per counter.
- The datapath is a single always block with a priority-encoded next-state.

## Test plan
- **Reset:** `rst_n`=0 for 2 cycles with random inputs → status=1, icode=1, rA=rB=F, vals=0, valid=0, counters=0.
- **Pass-through:** load icode=6, rA=2, rB=3, valE=0x1234 over 3 consecutive edges with stall=bubble=0 → each value appears 1 cycle later with valid=1; counters remain 0.
- **Stall:** load icode=3, then hold stall=1 for 4 edges while the inputs change → outputs stay at icode=3; stall_cnt=4.
- **Bubble and conflict:** stall=1 with bubble=1 for 1 edge → NOP bubble loaded, valid=0, conflict=1, bubble_cnt=1, stall_cnt unchanged.
- **Freeze:** with FREEZE_ON_EXC=1, load status=ADR(3) → frozen=1 and outputs held through 10 edges of new inputs and bubbles; then rst_n=0 → bubble state, frozen=0.
- **Saturation:** with CNT_W=3, hold stall=1 for 10 edges → stall_cnt=7 and stays at 7.
